// File: rtl/debug_cmd_sequencer_pkg.sv
// Shared definitions for the debug command sequencer: host command bytes,
// FSM state encoding and the width helpers used to size derived ports.
package debug_cmd_sequencer_pkg;

    localparam logic [7:0] CMD_RUN   = 8'h63;  // 'c'
    localparam logic [7:0] CMD_PAUSE = 8'h70;  // 'p'
    localparam logic [7:0] CMD_STEP  = 8'h73;  // 's'
    localparam logic [7:0] CMD_NSTEP = 8'h6E;  // 'n'
    localparam logic [7:0] CMD_DUMP  = 8'h64;  // 'd'

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_CNT = 3'd1,
        ST_STEP    = 3'd2,
        ST_DUMP_RD = 3'd3,
        ST_DUMP_TX = 3'd4
    } state_t;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // A counter for n items never shrinks below one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debug_word_serializer.sv
// Loads one snapshot word and streams it out LSB byte first over tx_valid/tx_ready;
// word_done pulses combinationally on the handshake of the last byte.
module debug_word_serializer
    import debug_cmd_sequencer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic              tx_ready_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    output logic              word_done_o
);

    localparam int BPW     = (DATA_W + 7) / 8;
    localparam int SHIFT_W = BPW * 8;
    localparam int SEL_W   = width_of(BPW);

    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               valid_q, valid_d;
    logic               handshake;
    logic               last_byte;

    // Handshake: a byte moves on a rising edge where tx_valid & tx_ready; once raised,
    // tx_valid holds and tx_data stays constant until that edge.
    assign handshake   = valid_q & tx_ready_i;
    assign last_byte   = (sel_q == SEL_W'(BPW - 1));
    assign word_done_o = handshake & last_byte;
    assign tx_data_o   = shift_q[7:0];
    assign tx_valid_o  = valid_q;

    always_comb begin
        shift_d = shift_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        if (load_i) begin
            shift_d = SHIFT_W'(word_i);
            sel_d   = '0;
            valid_d = 1'b1;
        end else if (handshake) begin
            shift_d = shift_q >> 8;
            if (last_byte) begin
                sel_d   = '0;
                valid_d = 1'b0;
            end else begin
                sel_d = sel_q + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/debug_cmd_sequencer.sv
// Host debug command engine: decodes UART bytes into run/pause/step/N-step/dump,
// gates the core clock-enable and streams the snapshot bus out on dump.
module debug_cmd_sequencer
    import debug_cmd_sequencer_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int NUM_WORDS = 64,
    parameter  int CNT_W     = 8,
    localparam int IDX_W     = width_of(NUM_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [IDX_W-1:0]  snap_idx,
    input  logic [DATA_W-1:0] snap_word,
    output logic              cpu_en,
    output logic              busy,
    output logic              err_pulse,
    output state_t            dbg_state
);

    localparam int CNT_BYTES = CNT_W / 8;
    localparam int NB_W      = width_of(CNT_BYTES);

    state_t           state_q, state_d;
    logic             run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NB_W-1:0]  nb_q, nb_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             cpu_en_q, cpu_en_d;
    logic             err_q, err_d;
    logic             ser_load;
    logic             word_done;

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        cnt_d    = cnt_q;
        nb_d     = nb_q;
        idx_d    = idx_q;
        err_d    = 1'b0;
        ser_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_RUN:   run_d = 1'b1;
                        CMD_PAUSE: run_d = 1'b0;
                        CMD_STEP: begin
                            cnt_d   = CNT_W'(1);
                            state_d = ST_STEP;
                        end
                        CMD_NSTEP: begin
                            cnt_d   = '0;
                            nb_d    = '0;
                            state_d = ST_GET_CNT;
                        end
                        CMD_DUMP: begin
                            idx_d   = '0;
                            state_d = ST_DUMP_RD;
                        end
                        default:   err_d = 1'b1;
                    endcase
                end
            end
            ST_GET_CNT: begin
                if (rx_valid) begin
                    // Count bytes arrive LSB first, so each new byte enters at the top.
                    cnt_d = (CNT_W'(rx_data) << (CNT_W - 8)) | (cnt_q >> 8);
                    if (nb_q == NB_W'(CNT_BYTES - 1)) begin
                        state_d = (cnt_d == '0) ? ST_IDLE : ST_STEP;
                    end else begin
                        nb_d = nb_q + NB_W'(1);
                    end
                end
            end
            ST_STEP: begin
                if (rx_valid && rx_data == CMD_PAUSE) begin
                    run_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    err_d = rx_valid;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DUMP_RD: begin
                err_d    = rx_valid;
                ser_load = 1'b1;
                state_d  = ST_DUMP_TX;
            end
            ST_DUMP_TX: begin
                err_d = rx_valid;
                if (word_done) begin
                    if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_DUMP_RD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered from next-state so cpu_en lines up exactly with the STEP cycles
    // and follows 'c'/'p' one cycle after the byte.
    assign cpu_en_d = (state_d == ST_STEP) | ((state_d == ST_IDLE) & run_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            run_q    <= 1'b0;
            cnt_q    <= '0;
            nb_q     <= '0;
            idx_q    <= '0;
            cpu_en_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            nb_q     <= nb_d;
            idx_q    <= idx_d;
            cpu_en_q <= cpu_en_d;
            err_q    <= err_d;
        end
    end

    debug_word_serializer #(
        .DATA_W (DATA_W)
    ) u_serializer (
        .clk         (clk),
        .reset       (reset),
        .load_i      (ser_load),
        .word_i      (snap_word),
        .tx_ready_i  (tx_ready),
        .tx_data_o   (tx_data),
        .tx_valid_o  (tx_valid),
        .word_done_o (word_done)
    );

    assign snap_idx  = idx_q;
    assign cpu_en    = cpu_en_q;
    assign err_pulse = err_q;
    assign busy      = (state_q != ST_IDLE) | run_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// Self-checking bench for debug_cmd_sequencer: command vector table plus
// hand-written run, pause-abort, dump and reset-during-dump sequences.
module tb_debug_cmd_sequencer;
    import debug_cmd_sequencer_pkg::*;

    localparam int DATA_W    = 32;
    localparam int NUM_WORDS = 4;
    localparam int CNT_W     = 8;
    localparam int IDX_W     = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [IDX_W-1:0]  snap_idx;
    logic [DATA_W-1:0] snap_word;
    logic              cpu_en;
    logic              busy;
    logic              err_pulse;
    state_t            dbg_state;

    int pass_cnt = 0;
    int total_cnt = 0;
    int en_total = 0;
    int err_total = 0;
    logic [7:0] exp_q[$];

    debug_cmd_sequencer #(
        .DATA_W    (DATA_W),
        .NUM_WORDS (NUM_WORDS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .snap_idx  (snap_idx),
        .snap_word (snap_word),
        .cpu_en    (cpu_en),
        .busy      (busy),
        .err_pulse (err_pulse),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / snapshot source / monitors ----------------
    always #5 clk = ~clk;

    // Byte k of word i is i*16+k, so LSB-first ordering is visible on the wire.
    assign snap_word = {2'b00, snap_idx, 4'd3, 2'b00, snap_idx, 4'd2,
                        2'b00, snap_idx, 4'd1, 2'b00, snap_idx, 4'd0};

    always @(negedge clk) begin
        if (cpu_en)    en_total  <= en_total + 1;
        if (err_pulse) err_total <= err_total + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    // ---------------- checking / driver tasks ----------------
    task automatic check(input string name, input int actual, input int expected);
        total_cnt++;
        if (actual == expected) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    // Called on a falling edge; returns on the next falling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_dump(input int inject_at, input bit expect_run, input string tag);
        int         hs = 0;
        int         en_hits = 0;
        int         stall_bad = 0;
        int         e0;
        bit         stalled = 1'b0;
        logic [7:0] held = 8'h00;
        logic [7:0] exp_b;
        exp_q.delete();
        for (int i = 0; i < NUM_WORDS; i++)
            for (int k = 0; k < 4; k++)
                exp_q.push_back(8'(i * 16 + k));
        e0 = err_total;
        send_byte(CMD_DUMP);
        for (int cyc = 0; cyc < 400 && hs < 16; cyc++) begin
            if (cpu_en) en_hits++;
            if (stalled && (!tx_valid || tx_data != held)) stall_bad++;
            tx_ready = ($urandom_range(0, 3) != 0);
            if (cyc == inject_at) begin
                rx_data  = CMD_STEP;
                rx_valid = 1'b1;
            end else begin
                rx_valid = 1'b0;
            end
            stalled = 1'b0;
            if (tx_valid) begin
                if (tx_ready) begin
                    exp_b = exp_q.pop_front();
                    check($sformatf("%s_byte%0d", tag, hs), tx_data, exp_b);
                    hs++;
                end else begin
                    stalled = 1'b1;
                    held    = tx_data;
                end
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        check({tag, "_byte_count"}, hs, 16);
        check({tag, "_cpu_en_during"}, en_hits, 0);
        check({tag, "_stall_stable"}, stall_bad, 0);
        check({tag, "_cpu_en_after"}, cpu_en, expect_run);
        check({tag, "_busy_after"}, busy, expect_run);
        idle(5);
        check({tag, "_no_extra_tx"}, tx_valid, 0);
        check({tag, "_err_count"}, err_total - e0, (inject_at >= 0) ? 1 : 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        int         nb;
        int         exp_en;
        int         exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int e0;
        int r0;

        vecs[0] = '{8'h73, 8'h00, 1, 1, 0};  // 's'
        vecs[1] = '{8'h6E, 8'h05, 2, 5, 0};  // 'n', 5
        vecs[2] = '{8'h6E, 8'h00, 2, 0, 0};  // 'n', 0
        vecs[3] = '{8'h41, 8'h00, 1, 0, 1};  // unknown 'A'
        vecs[4] = '{8'h6E, 8'h03, 2, 3, 0};  // 'n', 3
        vecs[5] = '{8'hFF, 8'h00, 1, 0, 1};  // unknown 0xFF
        vecs[6] = '{8'h70, 8'h00, 1, 0, 0};  // 'p' while paused
        vecs[7] = '{8'h6E, 8'h01, 2, 1, 0};  // 'n', 1

        // ---- reset ----
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        #4;
        check("rst_cpu_en", cpu_en, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_pulse, 0);
        #5 reset = 1'b0;
        @(negedge clk);
        check("post_rst_cpu_en", cpu_en, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_tx_valid", tx_valid, 0);
        check("post_rst_tx_data", tx_data, 0);
        check("post_rst_snap_idx", snap_idx, 0);
        check("post_rst_state", int'(dbg_state), int'(ST_IDLE));

        // ---- command vectors ----
        for (int i = 0; i < 8; i++) begin
            e0 = en_total;
            r0 = err_total;
            send_byte(vecs[i].b0);
            if (vecs[i].nb == 2) send_byte(vecs[i].b1);
            idle(30);
            check($sformatf("vec%0d_en_cycles", i), en_total - e0, vecs[i].exp_en);
            check($sformatf("vec%0d_err", i), err_total - r0, vecs[i].exp_err);
            check($sformatf("vec%0d_busy", i), busy, 0);
        end

        // ---- 'c' then 'p' 20 cycles later ----
        e0 = en_total;
        send_byte(CMD_RUN);
        check("run_first_cycle", cpu_en, 1);
        check("run_busy", busy, 1);
        idle(19);
        send_byte(CMD_PAUSE);
        check("pause_drops", cpu_en, 0);
        idle(10);
        check("run_en_cycles", en_total - e0, 20);
        check("pause_busy", busy, 0);

        // ---- 'p' aborts a long N-step and clears run mode ----
        e0 = en_total;
        r0 = err_total;
        send_byte(CMD_RUN);
        send_byte(CMD_NSTEP);
        send_byte(8'hFF);
        idle(10);
        send_byte(CMD_PAUSE);
        check("abort_stops", cpu_en, 0);
        idle(20);
        check("abort_en_cycles", en_total - e0, 12);
        check("abort_busy", busy, 0);
        check("abort_err", err_total - r0, 0);

        // ---- dump with stalls and an 's' rejected mid-dump ----
        run_dump(5, 1'b0, "dump");

        // ---- dump while running: core frozen, resumes on return ----
        send_byte(CMD_RUN);
        idle(3);
        check("prerun_cpu_en", cpu_en, 1);
        run_dump(-1, 1'b1, "rundump");
        send_byte(CMD_PAUSE);
        idle(5);
        check("rundump_pause_busy", busy, 0);

        // ---- reset asserted while a byte is pending in DUMP_TX ----
        tx_ready = 1'b0;
        send_byte(CMD_DUMP);
        idle(2);
        check("midrst_tx_valid_before", tx_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_tx_valid_async", tx_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_state", int'(dbg_state), int'(ST_IDLE));
        @(negedge clk);
        reset = 1'b0;
        idle(3);
        check("midrst_tx_valid_after", tx_valid, 0);
        check("midrst_snap_idx", snap_idx, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
